kogge_stone_approx_pipe: RTL and testbench
==========================================

KOGGE_STONE_APPROX_PIPE -- requirements
Module: kogge_stone_approx_pipe

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits; legal values are powers of two, 4..64.
REQ-002 Parameter APPROX_K, default 8: number of low bits in the approximate region; legal range 0..WIDTH-1.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 A  input  WIDTH  operand A.
REQ-006 B  input  WIDTH  operand B.
REQ-007 Cin  input  1  carry-in.
REQ-008 approx_en  input  1  per-transaction mode: 1 = approximate add, 0 = exact add.
REQ-009 in_valid / in_ready  input / output  1 each  input handshake.
REQ-010 Sum  output  WIDTH  result.
REQ-011 Cout  output  1  carry-out.
REQ-012 out_valid / out_ready  output / input  1 each  output handshake.
REQ-013 err_flag  output  1  result of the current output differs from the exact sum.
REQ-014 err_count  output  16  count of mismatching transactions.

Function
REQ-015 Input transfer: in_valid && in_ready on a rising edge; output transfer: out_valid && out_ready on a rising edge.
REQ-016 approx_en, A, B and Cin SHALL be captured together and travel with their transaction; a mode change affects only new transactions.
REQ-017 Exact mode: {Cout,Sum} = A + B + Cin.
REQ-018 Approximate mode with APPROX_K > 0:
- Sum[i] = A[i] | B[i] for i < APPROX_K.
- Carry into bit APPROX_K = A[APPROX_K-1] & B[APPROX_K-1].
- Cin is ignored.
- Bits APPROX_K..WIDTH-1 and Cout are computed exactly with Kogge-Stone prefix logic.
REQ-019 Approximate mode with APPROX_K = 0 SHALL equal exact mode.
REQ-020 Pipeline:
- One register stage for generate/propagate.
- One register stage per prefix level, clog2(WIDTH) levels.
- One sum/output stage.
- Latency LAT = clog2(WIDTH)+2 cycles; LAT = 6 for WIDTH = 16.
REQ-021 Throughput SHALL be one transaction per cycle while out_ready is high.
REQ-022 Global stall:
- in_ready = !(out_valid && !out_ready).
- While stalled, every stage holds its contents and Sum, Cout, err_flag and out_valid stay stable.
REQ-023 Bubbles SHALL propagate as invalid stages and are not collapsed.
REQ-024 Transactions SHALL leave in acceptance order with none lost or duplicated.
REQ-025 Simultaneous input and output transfer in the same cycle SHALL be legal and lossless.

Reset
REQ-026 While rst_n is low, all stage valid bits SHALL be 0, and out_valid = 0, Sum = 0, Cout = 0, err_flag = 0, err_count = 0.
REQ-027 In-flight transactions SHALL be discarded on reset.
REQ-028 After rst_n rises, no output SHALL appear until a new transaction has been accepted and LAT cycles have elapsed.

Configuration
REQ-029 Macro KSA_ERR_MON_EN defined: an exact reference sum travels alongside each transaction.
- err_flag = ({Cout,Sum} != exact sum) for the current output.
- err_count increments once per output transfer with err_flag = 1.
- err_count saturates at 0xFFFF.
REQ-030 Macro KSA_ERR_MON_EN undefined: err_flag and err_count SHALL be tied to 0, and no reference-sum logic SHALL be present.

Structure
REQ-031 Package ksa_pkg SHALL hold:
- the generate/propagate pair typedef;
- the constant function computing LAT from WIDTH;
- the err_count width constant (16).
REQ-032 Sub-module ksa_prefix_stage SHALL implement one registered prefix level, parametrised by WIDTH and level distance, with a stall enable; the top SHALL instantiate it clog2(WIDTH) times.

Verification (WIDTH = 16, APPROX_K = 8, macro defined, out_ready = 1 unless stated)
REQ-033 A=0xAAAA, B=0xCCCC, Cin=0, approx_en=0 -> after 6 cycles Sum=0x7776, Cout=1, err_flag=0.
REQ-034 Same operands, approx_en=1 -> Sum=0x77EE, Cout=1, err_flag=1, err_count increments to 1.
REQ-035 A=0xFFFF, B=0x0000, Cin=0, approx_en=1 -> Sum=0xFFFF, Cout=0, err_flag=0.
REQ-036 A=0x0000, B=0xFFFF, Cin=1:
- approx_en=0 -> Sum=0x0000, Cout=1.
- approx_en=1 -> Sum=0xFFFF, Cout=0, err_flag=1.
REQ-037 Backpressure: pipeline full, out_ready=0 for 3 cycles -> in_ready=0, outputs stable; after release all transactions emerge in order, one per cycle.
REQ-038 Reset mid-operation: rst_n pulsed low with 3 transactions in flight -> out_valid=0 and err_count=0 immediately; no stale result appears after release.

Source files
------------

// File: rtl/ksa_pkg.sv
// ksa_pkg: shared types and constants for the pipelined approximate Kogge-Stone adder.
// The optional error monitor in the top is enabled by the KSA_ERR_MON_EN macro.
package ksa_pkg;

    // Generate/propagate pair for one bit position or one prefix group.
    typedef struct packed {
        logic g;
        logic p;
    } ksa_gp_t;

    // Width of the mismatch counter.
    localparam int ERR_CNT_W = 16;

    // Pipeline latency: gp stage + one stage per prefix level + sum stage.
    function automatic int ksa_lat(input int width);
        return $clog2(width) + 2;
    endfunction

    // Kogge-Stone group combine: hi covers the more significant span.
    function automatic ksa_gp_t ksa_dot(input ksa_gp_t hi, input ksa_gp_t lo);
        ksa_gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/ksa_prefix_stage.sv
// ksa_prefix_stage: one registered Kogge-Stone prefix level at distance DIST.
// Side-band payload and the stage valid bit travel with the gp vector.
// All registers hold while en is low.
module ksa_prefix_stage
    import ksa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIST  = 1,
    parameter int PAY_W = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   vld_d,
    input  ksa_gp_t [WIDTH-1:0]    gp_d,
    input  logic [PAY_W-1:0]       pay_d,
    output logic                   vld_q,
    output ksa_gp_t [WIDTH-1:0]    gp_q,
    output logic [PAY_W-1:0]       pay_q
);

    ksa_gp_t [WIDTH-1:0] gp_nx;

    // Combine each position with the one DIST below; the low DIST positions pass through.
    always_comb begin
        gp_nx = gp_d;
        for (int i = DIST; i < WIDTH; i++) begin
            gp_nx[i] = ksa_dot(gp_d[i], gp_d[i-DIST]);
        end
    end

    // Stage register, frozen during a global stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            gp_q  <= '0;
            pay_q <= '0;
        end else if (en) begin
            vld_q <= vld_d;
            gp_q  <= gp_nx;
            pay_q <= pay_d;
        end
    end

endmodule

// File: rtl/kogge_stone_approx_pipe.sv
// kogge_stone_approx_pipe: pipelined adder with a per-transaction approximate mode.
// Approximate mode ORs the low APPROX_K bits, feeds A&B of bit APPROX_K-1 as the
// carry into the exact upper part, and ignores Cin.
// Pipeline: gp register, clog2(WIDTH) prefix registers, sum/output register.
// Define KSA_ERR_MON_EN to carry an exact reference sum and drive err_flag/err_count;
// otherwise both are tied to zero.
module kogge_stone_approx_pipe
    import ksa_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int APPROX_K = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      A,
    input  logic [WIDTH-1:0]      B,
    input  logic                  Cin,
    input  logic                  approx_en,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      Sum,
    output logic                  Cout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err_flag,
    output logic [ERR_CNT_W-1:0]  err_count
);

    localparam int LVLS = $clog2(WIDTH);

`ifdef KSA_ERR_MON_EN
    // payload = {exact reference {cout,sum}, carry-in, half-sum}
    localparam int PAY_W = 2*WIDTH + 2;
`else
    // payload = {carry-in, half-sum}
    localparam int PAY_W = WIDTH + 1;
`endif

    logic                 adv;
    logic                 approx_eff;
    logic                 cin_eff;
    ksa_gp_t [WIDTH-1:0]  gp_in;
    logic [WIDTH-1:0]     h_in;
    logic [PAY_W-1:0]     pay_in;

    logic                 s0_vld;
    ksa_gp_t [WIDTH-1:0]  s0_gp;
    logic [PAY_W-1:0]     s0_pay;

    logic                 lvl_vld [0:LVLS];
    ksa_gp_t [WIDTH-1:0]  lvl_gp  [0:LVLS];
    logic [PAY_W-1:0]     lvl_pay [0:LVLS];

    ksa_gp_t [WIDTH-1:0]  fin_gp;
    logic [WIDTH-1:0]     fin_h;
    logic                 fin_cin;
    logic [WIDTH-1:0]     carry;
    logic [WIDTH-1:0]     sum_nx;
    logic                 cout_nx;
    logic                 gp_p_unused;

    logic                 out_valid_q;
    logic [WIDTH-1:0]     sum_q;
    logic                 cout_q;

    // Whole pipeline advances unless a valid result is being held back.
    assign adv      = !(out_valid_q && !out_ready);
    assign in_ready = adv;

    // Per-bit generate/propagate and half-sum; approximate low bits are reshaped so
    // the shared prefix tree yields the approximate carries without a second path.
    always_comb begin
        approx_eff = approx_en && (APPROX_K > 0);
        cin_eff    = Cin && !approx_eff;
        for (int i = 0; i < WIDTH; i++) begin
            gp_in[i].g = A[i] & B[i];
            gp_in[i].p = A[i] ^ B[i];
            h_in[i]    = A[i] ^ B[i];
            if (approx_eff && (i < APPROX_K)) begin
                // Only bit APPROX_K-1 may generate; nothing propagates through the low region.
                gp_in[i].p = 1'b0;
                h_in[i]    = A[i] | B[i];
                if (i != APPROX_K - 1) begin
                    gp_in[i].g = 1'b0;
                end
            end
        end
        // Fold the carry-in into bit 0 so log2(WIDTH) levels still reach Cout.
        gp_in[0].g = gp_in[0].g | (gp_in[0].p & cin_eff);
    end

`ifdef KSA_ERR_MON_EN
    logic [WIDTH:0] ref_in;
    assign ref_in = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
    assign pay_in = {ref_in, cin_eff, h_in};
`else
    assign pay_in = {cin_eff, h_in};
`endif

    // gp stage: captures a transaction (or a bubble) whenever the pipeline advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_vld <= 1'b0;
            s0_gp  <= '0;
            s0_pay <= '0;
        end else if (adv) begin
            s0_vld <= in_valid;
            s0_gp  <= gp_in;
            s0_pay <= pay_in;
        end
    end

    assign lvl_vld[0] = s0_vld;
    assign lvl_gp[0]  = s0_gp;
    assign lvl_pay[0] = s0_pay;

    for (genvar l = 0; l < LVLS; l++) begin : g_lvl
        ksa_prefix_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << l),
            .PAY_W (PAY_W)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (adv),
            .vld_d (lvl_vld[l]),
            .gp_d  (lvl_gp[l]),
            .pay_d (lvl_pay[l]),
            .vld_q (lvl_vld[l+1]),
            .gp_q  (lvl_gp[l+1]),
            .pay_q (lvl_pay[l+1])
        );
    end

    assign fin_gp  = lvl_gp[LVLS];
    assign fin_h   = lvl_pay[LVLS][WIDTH-1:0];
    assign fin_cin = lvl_pay[LVLS][WIDTH];

    // Carries from the completed prefix: carry into bit i is the group generate of bits 0..i-1.
    always_comb begin
        carry    = '0;
        carry[0] = fin_cin;
        for (int i = 1; i < WIDTH; i++) begin
            carry[i] = fin_gp[i-1].g;
        end
        sum_nx  = fin_h ^ carry;
        cout_nx = fin_gp[WIDTH-1].g;
    end

    // Group propagates are not needed once the prefix is complete.
    always_comb begin
        gp_p_unused = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            gp_p_unused = gp_p_unused ^ fin_gp[i].p;
        end
    end

    // Output stage: result register and its valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
        end else if (adv) begin
            out_valid_q <= lvl_vld[LVLS];
            sum_q       <= sum_nx;
            cout_q      <= cout_nx;
        end
    end

    assign out_valid = out_valid_q;
    assign Sum       = sum_q;
    assign Cout      = cout_q;

`ifdef KSA_ERR_MON_EN
    logic                  err_nx;
    logic                  err_q;
    logic [ERR_CNT_W-1:0]  err_cnt_q;

    assign err_nx = lvl_vld[LVLS] && ({cout_nx, sum_nx} != lvl_pay[LVLS][PAY_W-1 -: WIDTH+1]);

    // Mismatch flag travels with the result in the output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (adv) begin
            err_q <= err_nx;
        end
    end

    // Count each delivered mismatching result once, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (out_valid_q && out_ready && err_q && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign err_flag  = err_q;
    assign err_count = err_cnt_q;
`else
    assign err_flag  = 1'b0;
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_kogge_stone_approx_pipe.sv
// tb_kogge_stone_approx_pipe: directed bench with an arithmetic reference model and
// a per-cycle compare process. Adapts its error-monitor expectations to KSA_ERR_MON_EN.
module tb_kogge_stone_approx_pipe;
    import ksa_pkg::*;

    localparam int W   = 16;
    localparam int K   = 8;
    localparam int LAT = ksa_lat(W);
`ifdef KSA_ERR_MON_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  A, B, Sum;
    logic          Cin, approx_en, in_valid, in_ready;
    logic          Cout, out_valid, out_ready, err_flag;
    logic [15:0]   err_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [17:0] q[$];
    int          merr = 0;
    bit          rnd_ready = 1'b0;
    logic        stalled_prev = 1'b0;
    logic [W-1:0] hold_sum;
    logic        hold_cout, hold_err;

    kogge_stone_approx_pipe #(.WIDTH(W), .APPROX_K(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .approx_en (approx_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Sum       (Sum),
        .Cout      (Cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_flag  (err_flag),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Returns {err, cout, sum[15:0]} from plain integer arithmetic.
    function automatic logic [17:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic ap);
        longint unsigned ua, ub, ex, ax, c;
        ua = 64'(a);
        ub = 64'(b);
        ex = ua + ub + 64'(cin);
        if (ap && (K > 0)) begin
            c  = (ua >> (K-1)) & (ub >> (K-1)) & 64'd1;
            ax = (((ua >> K) + (ub >> K) + c) << K) | ((ua | ub) & ((64'd1 << K) - 64'd1));
        end else begin
            ax = ex;
        end
        return {ERR_ON && (ax != ex), ax[16:0]};
    endfunction

    // Compare process: checks handshake, stall stability and every delivered result.
    initial begin
        logic [17:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                merr = 0;
                stalled_prev = 1'b0;
            end else begin
                chk("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
                chk("err_count", 64'(err_count), 64'(merr));
                if (stalled_prev) begin
                    chk("stall_valid", 64'(out_valid), 64'd1);
                    chk("stall_sum", 64'(Sum), 64'(hold_sum));
                    chk("stall_cout", 64'(Cout), 64'(hold_cout));
                    chk("stall_err", 64'(err_flag), 64'(hold_err));
                end
                if (out_valid && out_ready) begin
                    chk("out_pending", 64'(q.size() != 0), 64'd1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        chk("out_sum", 64'(Sum), 64'(e[15:0]));
                        chk("out_cout", 64'(Cout), 64'(e[16]));
                        chk("out_err", 64'(err_flag), 64'(e[17]));
                        if (e[17] && merr < 65535) merr++;
                    end
                end
                stalled_prev = out_valid && !out_ready;
                hold_sum  = Sum;
                hold_cout = Cout;
                hold_err  = err_flag;
                if (in_valid && in_ready) q.push_back(model(A, B, Cin, approx_en));
            end
        end
    end

    // Random backpressure, applied only while enabled.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (rnd_ready) out_ready = (($urandom % 3) != 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic ap);
        int   guard;
        logic took;
        guard = 0;
        took  = 1'b0;
        A = a; B = b; Cin = cin; approx_en = ap; in_valid = 1'b1;
        do begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!took && guard < 100);
        chk("drive_accept", 64'(took), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic single(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic ap, input logic [W-1:0] es,
                          input logic ec, input logic ee, input int ecnt);
        int n;
        A = a; B = b; Cin = cin; approx_en = ap; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 4*LAT) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_latency"}, 64'(n), 64'(LAT));
        chk({name, "_sum"}, 64'(Sum), 64'(es));
        chk({name, "_cout"}, 64'(Cout), 64'(ec));
        chk({name, "_errflag"}, 64'(err_flag), 64'(ee && ERR_ON));
        @(posedge clk);
        #1;
        chk({name, "_errcount"}, 64'(err_count), 64'(ERR_ON ? ecnt : 0));
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((q.size() != 0 || out_valid) && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int streak;
        A = '0; B = '0; Cin = 1'b0; approx_en = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b0;

        // Hand-computed pins on the model itself.
        chk("model_exact_aaaa", 64'(model(16'hAAAA, 16'hCCCC, 1'b0, 1'b0)), 64'({1'b0, 17'h17776}));
        chk("model_apx_aaaa",   64'(model(16'hAAAA, 16'hCCCC, 1'b0, 1'b1)), 64'({ERR_ON, 17'h177EE}));
        chk("model_apx_ffff",   64'(model(16'hFFFF, 16'h0000, 1'b0, 1'b1)), 64'({1'b0, 17'h0FFFF}));
        chk("model_exact_cin",  64'(model(16'h0000, 16'hFFFF, 1'b1, 1'b0)), 64'({1'b0, 17'h10000}));
        chk("model_apx_cin",    64'(model(16'h0000, 16'hFFFF, 1'b1, 1'b1)), 64'({ERR_ON, 17'h0FFFF}));

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(Sum), 64'd0);
        chk("rst_cout", 64'(Cout), 64'd0);
        chk("rst_err_flag", 64'(err_flag), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Directed single transactions with literal expectations.
        single("exact_aaaa", 16'hAAAA, 16'hCCCC, 1'b0, 1'b0, 16'h7776, 1'b1, 1'b0, 0);
        single("apx_aaaa",   16'hAAAA, 16'hCCCC, 1'b0, 1'b1, 16'h77EE, 1'b1, 1'b1, 1);
        single("apx_ffff",   16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1);
        single("exact_cin",  16'h0000, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1);
        single("apx_cin",    16'h0000, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b1, 2);

        // Back-to-back stream with mode changes mid-flight; checked by the model.
        drive(16'h0000, 16'h0000, 1'b1, 1'b1);
        drive(16'h00FF, 16'h0001, 1'b0, 1'b1);
        drive(16'h00FF, 16'h0001, 1'b0, 1'b0);
        drive(16'h0080, 16'h0080, 1'b1, 1'b1);
        drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        drive(16'h8000, 16'h8000, 1'b0, 1'b1);
        drive(16'h1234, 16'h4321, 1'b1, 1'b0);
        drive(16'h7F7F, 16'h0101, 1'b0, 1'b1);
        drive(16'h7F7F, 16'h0101, 1'b1, 1'b0);
        drain();

        // Random operands with bubbles and random backpressure.
        rnd_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (($urandom % 4) == 0) begin
                @(posedge clk);
                #1;
            end
            drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        drain();

        // Backpressure with a full pipeline.
        for (int i = 0; i < 8; i++) begin
            drive(16'h1111 * 16'(i + 1), 16'hF0F0 ^ 16'(i), 1'(i), 1'(i >> 1));
        end
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        chk("bp_full", 64'(q.size()), 64'(LAT));
        out_ready = 1'b1;
        streak = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!out_valid) break;
            streak++;
        end
        chk("bp_streak", 64'(streak), 64'(LAT));
        drain();

        // Reset in the middle of a stream.
        for (int i = 0; i < 6; i++) begin
            drive(16'hAAAA, 16'hCCCC ^ 16'(i), 1'b0, 1'b1);
        end
        #1;
        chk("midrst_pre_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_err_count", 64'(err_count), 64'd0);
        chk("midrst_sum", 64'(Sum), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        streak = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) streak++;
        end
        chk("midrst_no_stale", 64'(streak), 64'd0);
        @(posedge clk);
        #1;
        single("post_rst_exact", 16'hAAAA, 16'hCCCC, 1'b0, 1'b0, 16'h7776, 1'b1, 1'b0, 0);
        single("post_rst_apx",   16'hAAAA, 16'hCCCC, 1'b0, 1'b1, 16'h77EE, 1'b1, 1'b1, 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
